sobolrng_md: RTL

Parametrised multi-dimension Sobol quasirandom generator for unary/stochastic bitstream generation. One shared enabled counter and least-significant-zero (LSZ) encoder drive DIM independent Gray-code XOR accumulators. Each accumulator has its own runtime-loadable direction-vector table. Outputs feed the comparators of a DIM-input stochastic compute lane. A period-wrap pulse marks stream boundaries.

---
 rtl/sobolrng_pkg.sv | 22 ++
 rtl/sobolrng_lsz_p.sv | 26 ++
 rtl/sobolrng_md.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sobolrng_pkg.sv
// sobolrng_pkg: shared definitions for the multi-dimension Sobol generator.
//
// Optional feature macro: SOBOLRNG_SCRAMBLE_EN (undefined by default).
//   When defined, each dimension carries a scramble word that is XORed
//   into its output sample (digital shift).
//
// Contents:
//   MAX_BW       - widest supported sample width
//   dv_identity  - reset value of direction vector k: 1 << (bw-1-k),
//                  which makes every dimension a van der Corput sequence
package sobolrng_pkg;

    localparam int MAX_BW = 16;

    function automatic logic [MAX_BW-1:0] dv_identity(input int bw, input int k);
        logic [MAX_BW-1:0] v;
        v = '0;
        v[bw-1-k] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sobolrng_lsz_p.sv
// sobolrng_lsz_p: least-significant-zero priority encoder.
//
// Ports:
//   iVal      in  BITWIDTH  value to scan (the shared sequence counter)
//   oIdx      out IDXW      index of the lowest 0 bit (0 when iVal is all ones)
//   oAllOnes  out 1         iVal has no 0 bit
module sobolrng_lsz_p #(
    parameter int BITWIDTH = 8,
    parameter int IDXW     = $clog2(BITWIDTH + 1)
) (
    input  logic [BITWIDTH-1:0] iVal,
    output logic [IDXW-1:0]     oIdx,
    output logic                oAllOnes
);

    // Scan from the top down so the lowest zero wins.
    always_comb begin
        oIdx = '0;
        for (int i = BITWIDTH - 1; i >= 0; i--) begin
            if (!iVal[i]) oIdx = IDXW'(i);
        end
    end

    assign oAllOnes = &iVal;

endmodule

// File: rtl/sobolrng_md.sv
// sobolrng_md: parametrised multi-dimension Sobol quasirandom generator.
//
// One shared counter and LSZ encoder drive DIM Gray-code XOR accumulators,
// each with its own runtime-loadable direction-vector table. Outputs are
// registered; oWrap pulses on the step that returns the sequence to 0.
//
// Optional feature macro: SOBOLRNG_SCRAMBLE_EN (per-dimension digital shift
// word written through table index BITWIDTH).
//
// Ports:
//   iClk, iRstN  clock, async active-low reset (also restores identity tables)
//   iEn          advance one step
//   iClr         synchronous restart of counter/outputs, priority over iEn
//   iDvWe/iDvDim/iDvIdx/iDvData  direction-vector (or scramble) write port
//   oRand        DIM samples, dimension d at [d*BITWIDTH +: BITWIDTH]
//   oWrap        one-cycle period-wrap pulse
module sobolrng_md
    import sobolrng_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int DIM      = 2,
    parameter int IDXW     = $clog2(BITWIDTH + 1),
    parameter int DIMW     = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                    iClk,
    input  logic                    iRstN,
    input  logic                    iEn,
    input  logic                    iClr,
    input  logic                    iDvWe,
    input  logic [DIMW-1:0]         iDvDim,
    input  logic [IDXW-1:0]         iDvIdx,
    input  logic [BITWIDTH-1:0]     iDvData,
    output logic [DIM*BITWIDTH-1:0] oRand,
    output logic                    oWrap
);

    function automatic logic [BITWIDTH-1:0] ident(input int k);
        logic [MAX_BW-1:0] t;
        t = dv_identity(BITWIDTH, k);
        return t[BITWIDTH-1:0];
    endfunction

    logic [BITWIDTH-1:0]            cnt;
    logic [IDXW-1:0]                lsz_idx;
    logic                           all_ones;
    logic                           wrap;
    logic [DIM-1:0][BITWIDTH-1:0]   acc, acc_nxt, step_vec;
    logic [BITWIDTH-1:0]            tbl [DIM][BITWIDTH];
    logic [DIM-1:0]                 dim_hit;
    logic [BITWIDTH-1:0]            idx_hit;

    sobolrng_lsz_p #(.BITWIDTH(BITWIDTH), .IDXW(IDXW)) u_lsz (
        .iVal    (cnt),
        .oIdx    (lsz_idx),
        .oAllOnes(all_ones)
    );

    // Write decode; out-of-range dimension/index simply never matches.
    always_comb begin
        dim_hit = '0;
        idx_hit = '0;
        for (int d = 0; d < DIM; d++) dim_hit[d] = iDvWe && (int'(iDvDim) == d);
        for (int k = 0; k < BITWIDTH; k++) idx_hit[k] = (int'(iDvIdx) == k);
    end

    // Direction vector selected by the LSZ index (old table value on a
    // same-cycle write, since tbl only updates at the edge).
    always_comb begin
        step_vec = '0;
        for (int d = 0; d < DIM; d++) begin
            for (int k = 0; k < BITWIDTH; k++) begin
                if (int'(lsz_idx) == k) step_vec[d] = tbl[d][k];
            end
        end
    end

    always_comb begin
        acc_nxt = acc;
        if (iClr)
            acc_nxt = '0;
        else if (iEn)
            acc_nxt = all_ones ? '0 : (acc ^ step_vec);
    end

    // Counter wraps naturally from all-ones to 0 on the terminal step.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt  <= '0;
            acc  <= '0;
            wrap <= 1'b0;
        end else begin
            acc <= acc_nxt;
            if (iClr) begin
                cnt  <= '0;
                wrap <= 1'b0;
            end else if (iEn) begin
                cnt  <= cnt + BITWIDTH'(1);
                wrap <= all_ones;
            end else begin
                wrap <= 1'b0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int d = 0; d < DIM; d++)
                for (int k = 0; k < BITWIDTH; k++)
                    tbl[d][k] <= ident(k);
        end else begin
            for (int d = 0; d < DIM; d++)
                for (int k = 0; k < BITWIDTH; k++)
                    if (dim_hit[d] && idx_hit[k]) tbl[d][k] <= iDvData;
        end
    end

`ifdef SOBOLRNG_SCRAMBLE_EN
    logic [DIM-1:0][BITWIDTH-1:0] scr, scr_nxt, out_q;
    logic                         scr_sel;

    assign scr_sel = (int'(iDvIdx) == BITWIDTH);

    always_comb begin
        scr_nxt = scr;
        for (int d = 0; d < DIM; d++)
            if (dim_hit[d] && scr_sel) scr_nxt[d] = iDvData;
    end

    // Shift applied before the output register so a scramble write shows
    // up on the output right after the writing edge.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            scr   <= '0;
            out_q <= '0;
        end else begin
            scr   <= scr_nxt;
            out_q <= acc_nxt ^ scr_nxt;
        end
    end

    assign oRand = out_q;
`else
    assign oRand = acc;
`endif

    assign oWrap = wrap;

endmodule
